// File: rtl/branch_pkg.sv
// Shared control-transfer definitions: RV32 opcodes/funct3, resolution FSM states,
// 2-bit saturating predictor counter type and its update rule.
package branch_pkg;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_REDIRECT = 1'b1} state_e;

  typedef logic [1:0] ctr2_t;
  localparam ctr2_t CTR_INIT = 2'b01;

  function automatic ctr2_t ctr_next(input ctr2_t c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction
endpackage

// File: rtl/branch_ctrl_if.sv
// Fetch/execute/redirect signal bundle between the pipeline (master) and branch_ctrl (slave).
interface branch_ctrl_if #(parameter int XLEN = 32);
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [6:0]      if_opcode;
  logic [XLEN-1:0] if_imm;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid;
  logic [6:0]      ex_opcode;
  logic [XLEN-1:0] ex_pc;
  logic            ex_pred_taken;
  logic            ex_br_taken;
  logic [XLEN-1:0] ex_target;
  logic            stall;
  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [15:0]     br_count;
  logic [15:0]     mispred_count;

  modport slave (
    input  if_valid, if_pc, if_opcode, if_imm,
           ex_valid, ex_opcode, ex_pc, ex_pred_taken, ex_br_taken, ex_target, stall,
    output pred_taken, pred_target, flush, redirect_valid, redirect_pc,
           br_count, mispred_count
  );
  modport master (
    output if_valid, if_pc, if_opcode, if_imm,
           ex_valid, ex_opcode, ex_pc, ex_pred_taken, ex_br_taken, ex_target, stall,
    input  pred_taken, pred_target, flush, redirect_valid, redirect_pc,
           br_count, mispred_count
  );
endinterface

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: one async read port, one update port.
import branch_pkg::*;

module bht_2bit #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output ctr2_t            rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);
  ctr2_t tbl [ENTRIES];

  // Read is from the register array, so a same-cycle update is not bypassed.
  assign rd_ctr = tbl[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= CTR_INIT;
    end else if (wr_en) begin
      tbl[wr_idx] <= ctr_next(tbl[wr_idx], wr_taken);
    end
  end
endmodule

// File: rtl/branch_ctrl.sv
// Fetch-stage branch predictor plus EX-stage resolution: mispredict redirect FSM,
// BHT training and resolved/mispredicted transfer counters.
import branch_pkg::*;

module branch_ctrl #(
  parameter int BHT_ENTRIES = 16,
  parameter int XLEN        = 32
) (
  input logic         clk,
  input logic         rst,
  branch_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  state_e          state;
  logic [XLEN-1:0] rpc;
  logic [15:0]     br_cnt, mp_cnt;
  ctr2_t           rd_ctr;
  logic            if_b, if_jal, ex_cti, res_ev, mispred, ptk;

  // Fetch prediction
  assign if_b   = bus.if_opcode == OP_BRANCH;
  assign if_jal = bus.if_opcode == OP_JAL;
  assign ptk    = bus.if_valid & ((if_b & rd_ctr[1]) | if_jal);

  assign bus.pred_taken  = ptk;
  assign bus.pred_target = ptk ? bus.if_pc + bus.if_imm : bus.if_pc + XLEN'(4);

  // Execute resolution; anything seen while redirecting is wrong-path and ignored.
  assign ex_cti  = bus.ex_opcode inside {OP_BRANCH, OP_JAL, OP_JALR};
  assign res_ev  = bus.ex_valid & ~bus.stall & (state == ST_RUN) & ex_cti;
  assign mispred = res_ev & (bus.ex_br_taken != bus.ex_pred_taken);

  bht_2bit #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (bus.if_pc[IDX_W+1:2]),
    .rd_ctr   (rd_ctr),
    .wr_en    (res_ev & (bus.ex_opcode == OP_BRANCH)),
    .wr_idx   (bus.ex_pc[IDX_W+1:2]),
    .wr_taken (bus.ex_br_taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      rpc   <= '0;
    end else begin
      case (state)
        ST_RUN: if (mispred) begin
          state <= ST_REDIRECT;
          rpc   <= bus.ex_br_taken ? bus.ex_target : bus.ex_pc + XLEN'(4);
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (res_ev  && br_cnt != 16'hFFFF) br_cnt <= br_cnt + 16'd1;
      if (mispred && mp_cnt != 16'hFFFF) mp_cnt <= mp_cnt + 16'd1;
    end
  end

  // Outputs decode straight from the state flop so reset drops them asynchronously.
  assign bus.flush          = state == ST_REDIRECT;
  assign bus.redirect_valid = state == ST_REDIRECT;
  assign bus.redirect_pc    = rpc;
  assign bus.br_count       = br_cnt;
  assign bus.mispred_count  = mp_cnt;
endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: prediction, BHT training, redirect timing, stall,
// wrong-path suppression, async reset and counter saturation.
import branch_pkg::*;

module tb_branch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  branch_ctrl_if #(.XLEN(32)) bus ();

  branch_ctrl #(.BHT_ENTRIES(16), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic v, input logic [6:0] op, input logic [31:0] pc,
                        input logic [31:0] imm);
    bus.if_valid = v; bus.if_opcode = op; bus.if_pc = pc; bus.if_imm = imm;
  endtask

  task automatic set_ex(input logic v, input logic [6:0] op, input logic [31:0] pc,
                        input logic pt, input logic bt, input logic [31:0] tgt);
    bus.ex_valid = v; bus.ex_opcode = op; bus.ex_pc = pc;
    bus.ex_pred_taken = pt; bus.ex_br_taken = bt; bus.ex_target = tgt;
  endtask

  task automatic chk_pred(input string tag, input logic t, input logic [31:0] tgt);
    #1;
    chk({tag, "_taken"}, 32'(bus.pred_taken), 32'(t));
    chk({tag, "_target"}, bus.pred_target, tgt);
  endtask

  initial begin
    bus.stall = 1'b0;
    set_if(1'b0, 7'd0, 32'h0, 32'h0);
    set_ex(1'b0, 7'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    #12;
    chk("rst_flush", 32'(bus.flush), 32'h0);
    chk("rst_rv", 32'(bus.redirect_valid), 32'h0);
    chk("rst_rpc", bus.redirect_pc, 32'h0);
    chk("rst_br", 32'(bus.br_count), 32'h0);
    chk("rst_mp", 32'(bus.mispred_count), 32'h0);
    rst = 1'b0;
    step();

    // Fresh counter 01 -> not taken
    set_if(1'b1, OP_BRANCH, 32'h100, 32'h20);
    chk_pred("b_init", 1'b0, 32'h104);
    set_if(1'b1, OP_JAL, 32'h100, 32'h40);
    chk_pred("jal", 1'b1, 32'h140);
    set_if(1'b1, OP_JALR, 32'h100, 32'h40);
    chk_pred("jalr", 1'b0, 32'h104);
    set_if(1'b0, OP_JAL, 32'h100, 32'h40);
    chk_pred("inval", 1'b0, 32'h104);

    // Train index 0 (pc 0x100) taken: 01 -> 10 -> 11 -> 11
    set_if(1'b1, OP_BRANCH, 32'h100, 32'h20);
    set_ex(1'b1, OP_BRANCH, 32'h100, 1'b1, 1'b1, 32'h120);
    repeat (3) step();
    chk_pred("b_trained", 1'b1, 32'h120);
    chk("br_after3", 32'(bus.br_count), 32'd3);
    step();
    chk_pred("b_sat11", 1'b1, 32'h120);
    chk("br_after4", 32'(bus.br_count), 32'd4);
    chk("mp_none", 32'(bus.mispred_count), 32'd0);

    // Not-taken decrements: 11 -> 10 (still taken), then 10 -> 01
    set_ex(1'b1, OP_BRANCH, 32'h100, 1'b0, 1'b0, 32'h120);
    step();
    chk_pred("b_dec10", 1'b1, 32'h120);
    step();
    chk_pred("b_dec01", 1'b0, 32'h104);
    chk("br_after6", 32'(bus.br_count), 32'd6);

    // Mispredict at 0x104 (idx 1), then wrong-path B at 0x100 during REDIRECT
    set_ex(1'b1, OP_BRANCH, 32'h104, 1'b0, 1'b1, 32'h200);
    #1;
    chk("pre_flush", 32'(bus.flush), 32'h0);
    step();
    chk("mp_flush", 32'(bus.flush), 32'h1);
    chk("mp_rv", 32'(bus.redirect_valid), 32'h1);
    chk("mp_rpc", bus.redirect_pc, 32'h200);
    chk("mp_cnt1", 32'(bus.mispred_count), 32'd1);
    chk("mp_br7", 32'(bus.br_count), 32'd7);
    set_ex(1'b1, OP_BRANCH, 32'h100, 1'b0, 1'b1, 32'h300);
    step();
    set_ex(1'b0, 7'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("post_flush", 32'(bus.flush), 32'h0);
    chk("post_rv", 32'(bus.redirect_valid), 32'h0);
    chk("wp_br", 32'(bus.br_count), 32'd7);
    chk("wp_mp", 32'(bus.mispred_count), 32'd1);
    chk_pred("wp_bht", 1'b0, 32'h104);
    set_if(1'b1, OP_BRANCH, 32'h104, 32'h20);
    chk_pred("idx1_10", 1'b1, 32'h124);

    // Stalled JALR mispredict waits for stall release; JALR does not train BHT
    bus.stall = 1'b1;
    set_ex(1'b1, OP_JALR, 32'h100, 1'b0, 1'b1, 32'h3C0);
    step();
    chk("stall_flush", 32'(bus.flush), 32'h0);
    chk("stall_br", 32'(bus.br_count), 32'd7);
    bus.stall = 1'b0;
    step();
    set_ex(1'b0, 7'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("jalr_flush", 32'(bus.flush), 32'h1);
    chk("jalr_rpc", bus.redirect_pc, 32'h3C0);
    chk("jalr_br", 32'(bus.br_count), 32'd8);
    set_if(1'b1, OP_BRANCH, 32'h100, 32'h20);
    chk_pred("jalr_nobht", 1'b0, 32'h104);

    // Reset mid-REDIRECT, between clock edges
    #1;
    rst = 1'b1;
    #1;
    chk("arst_flush", 32'(bus.flush), 32'h0);
    chk("arst_rv", 32'(bus.redirect_valid), 32'h0);
    chk("arst_rpc", bus.redirect_pc, 32'h0);
    chk("arst_br", 32'(bus.br_count), 32'h0);
    chk("arst_mp", 32'(bus.mispred_count), 32'h0);
    rst = 1'b0;
    step();
    chk("arst_flush2", 32'(bus.flush), 32'h0);
    set_if(1'b1, OP_BRANCH, 32'h104, 32'h20);
    chk_pred("arst_idx1", 1'b0, 32'h108);

    // Correctly predicted JALs saturate br_count
    set_ex(1'b1, OP_JAL, 32'h80, 1'b1, 1'b1, 32'h90);
    repeat (65540) @(posedge clk);
    #1;
    chk("br_sat", 32'(bus.br_count), 32'hFFFF);
    chk("mp_sat0", 32'(bus.mispred_count), 32'h0);
    chk("sat_flush", 32'(bus.flush), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 16, number of 2-bit predictor counters (power of two, 4..256).
REQ-002 SHALL have parameter XLEN, default 32, address/data width.
REQ-003 SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 if_valid  input  1  fetch-stage instruction valid.
REQ-007 if_pc  input  XLEN  fetch-stage PC.
REQ-008 if_opcode  input  7  predecoded opcode of fetched instruction.
REQ-009 if_imm  input  XLEN  sign-extended B/J immediate of fetched instruction.
REQ-010 pred_taken  output  1  fetch prediction, combinational.
REQ-011 pred_target  output  XLEN  predicted target, combinational.
REQ-012 ex_valid  input  1  execute-stage instruction valid.
REQ-013 ex_opcode  input  7  execute-stage opcode.
REQ-014 ex_pc  input  XLEN  execute-stage PC.
REQ-015 ex_pred_taken  input  1  prediction carried down the pipe with the instruction.
REQ-016 ex_br_taken  input  1  resolved outcome from the branch comparator.
REQ-017 ex_target  input  XLEN  resolved taken target (ALU).
REQ-018 stall  input  1  pipeline stall; freezes EX resolution.
REQ-019 flush  output  1  kill IF/ID/EX wrong-path instructions.
REQ-020 redirect_valid  output  1  load redirect_pc into PC.
REQ-021 redirect_pc  output  XLEN  corrected fetch address.
REQ-022 br_count  output  16  resolved control-transfer count.
REQ-023 mispred_count  output  16  mispredict count.

Function
REQ-024 Index SHALL be pc[log2(BHT_ENTRIES)+1:2]; counters 2-bit saturating (00 strong NT .. 11 strong T).
REQ-025 Prediction: B-type (1100011) -> pred_taken = counter[1]; JAL (1101111) -> 1; JALR (1100111), other opcodes or if_valid=0 -> 0.
REQ-026 pred_target SHALL be if_pc + if_imm (modulo 2^XLEN) when pred_taken=1, else if_pc + 4.
REQ-027 Resolution event SHALL be ex_valid & !stall & state==RUN & opcode in {B, JAL, JALR}.
REQ-028 Mispredict SHALL be a resolution event with ex_br_taken != ex_pred_taken.
REQ-029 FSM states RUN, REDIRECT; RUN->REDIRECT on mispredict; REDIRECT->RUN unconditionally after one cycle.
REQ-030 In REDIRECT: flush=1, redirect_valid=1, redirect_pc = registered (ex_br_taken ? ex_target : ex_pc+4) captured at the mispredict edge; in RUN both 0.
REQ-031 Latency: mispredict in EX cycle N -> redirect_valid/flush high exactly in cycle N+1, one cycle only.
REQ-032 EX inputs in REDIRECT SHALL be ignored (wrong-path): no BHT update, no counting.
REQ-033 BHT update on each B-type resolution event: taken increments, not-taken decrements, saturating at 11/00; JAL/JALR do not update.
REQ-034 Same-index lookup and update in one cycle: prediction uses the pre-update counter (no bypass).
REQ-035 br_count increments per resolution event; mispred_count per mispredict; both saturate at 0xFFFF.
REQ-036 stall=1 SHALL freeze BHT, counters and FSM in RUN; prediction outputs remain live.

Reset
REQ-037 rst SHALL asynchronously force state RUN, all counters to 01, flush=0, redirect_valid=0, redirect_pc=0, br_count=0, mispred_count=0.
REQ-038 rst asserted during REDIRECT SHALL drop flush/redirect_valid immediately; no pending redirect survives.

Structure
REQ-039 Shared package branch_pkg SHALL hold opcode constants (B, JAL, JALR), branch funct3 constants, the state enum and the 2-bit counter typedef.
REQ-040 Counter array SHALL be one sub-module, bht_2bit (read port, saturating update port).

Verification
REQ-041 Reset, B at if_pc=0x100 -> pred_taken=0, pred_target=0x104.
REQ-042 Three taken resolutions at ex_pc=0x100 -> counter 11; next fetch 0x100, if_imm=0x20 -> pred_taken=1, pred_target=0x120; fourth taken keeps 11.
REQ-043 ex_pred_taken=0, ex_br_taken=1, ex_target=0x200 -> next cycle flush=1, redirect_valid=1, redirect_pc=0x200, mispred_count=1; following cycle both 0.
REQ-044 Mispredict then a valid B in EX during REDIRECT -> no BHT change, br_count unchanged.
REQ-045 JALR resolution (pred 0, taken, ex_target=0x3C0) with stall=1 -> no action; stall released -> redirect_pc=0x3C0 next cycle.
REQ-046 Assert rst mid-REDIRECT -> flush=0 asynchronously, counters reset, first post-reset B predicts not-taken.
